// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode -- PDP-8 front end: fetch, decode, effective-address
// resolution, and hand-off of one instruction at a time to EXEC.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   ifu_rd_req/addr/data  memory read port (data returns the cycle after req)
//   ifu_wr_req/addr/data  autoindex write-back port (all zero unless AUTOINDEX_EN)
//   stall, PC_value       EXEC handshake; PC_value taken when stall falls
//   base_addr             effective address of the issued memory instruction
//   pdp_mem_opcode        one-hot memory-reference opcode plus address
//   pdp_op7_opcode        one-hot operate microinstruction
//   halted                set once HLT (7402) has been decoded
//
// Optional feature macro: AUTOINDEX_EN -- indirect references through
// 0010-0017 pre-increment the pointer and write it back before issue.

`ifndef PDP_START_ADDRESS
`define PDP_START_ADDRESS 12'o0200
`endif

package pdp_pkg;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    typedef struct packed {
        logic        AND;
        logic        TAD;
        logic        ISZ;
        logic        DCA;
        logic        JMS;
        logic        JMP;
        logic [11:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA;
        logic CLA_CLL;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;
endpackage

module instr_fetch_decode
    import pdp_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = `PDP_START_ADDRESS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_wr_req,
    output logic [ADDR_WIDTH-1:0] ifu_wr_addr,
    output logic [DATA_WIDTH-1:0] ifu_wr_data,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    output logic                  halted
);

    typedef enum logic [3:0] {
        FETCH_REQ, FETCH_WAIT, DECODE, IND_REQ, IND_WAIT,
        AUTO_WR, ISSUE, EXEC_WAIT, HALT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    pdp_mem_opcode_s       mem_q, mem_d;
    pdp_op7_opcode_s       op7_q, op7_d;

    // Decode of the held IR; only copied into the output registers on the
    // transition into ISSUE so the outputs stay zero during address resolution.
    pdp_mem_opcode_s       mem_dec;
    pdp_op7_opcode_s       op7_dec;
    logic [ADDR_WIDTH-1:0] dir_addr;

    // Page bit selects current page (upper PC bits) or page zero.
    assign dir_addr = ir_q[7] ? {fetch_pc_q[11:7], ir_q[6:0]} : {5'b0, ir_q[6:0]};

`ifdef AUTOINDEX_EN
    logic [DATA_WIDTH-1:0] auto_q, auto_d;
    logic                  is_auto;
    assign is_auto = (dir_addr[11:3] == 9'b0_0000_0001);
`endif

    always_comb begin
        mem_dec = '0;
        case (ir_q[11:9])
            3'd0:    mem_dec.AND = 1'b1;
            3'd1:    mem_dec.TAD = 1'b1;
            3'd2:    mem_dec.ISZ = 1'b1;
            3'd3:    mem_dec.DCA = 1'b1;
            3'd4:    mem_dec.JMS = 1'b1;
            3'd5:    mem_dec.JMP = 1'b1;
            default: mem_dec = '0;
        endcase

        // Only exact microcode words are recognised; combinations issue as zero.
        op7_dec = '0;
        case (ir_q)
            12'o7000: op7_dec.NOP     = 1'b1;
            12'o7001: op7_dec.IAC     = 1'b1;
            12'o7004: op7_dec.RAL     = 1'b1;
            12'o7006: op7_dec.RTL     = 1'b1;
            12'o7010: op7_dec.RAR     = 1'b1;
            12'o7012: op7_dec.RTR     = 1'b1;
            12'o7020: op7_dec.CML     = 1'b1;
            12'o7040: op7_dec.CMA     = 1'b1;
            12'o7041: op7_dec.CIA     = 1'b1;
            12'o7100: op7_dec.CLL     = 1'b1;
            12'o7200: op7_dec.CLA     = 1'b1;
            12'o7300: op7_dec.CLA_CLL = 1'b1;
            12'o7404: op7_dec.OSR     = 1'b1;
            12'o7410: op7_dec.SKP     = 1'b1;
            12'o7420: op7_dec.SNL     = 1'b1;
            12'o7430: op7_dec.SZL     = 1'b1;
            12'o7440: op7_dec.SZA     = 1'b1;
            12'o7450: op7_dec.SNA     = 1'b1;
            12'o7500: op7_dec.SMA     = 1'b1;
            12'o7510: op7_dec.SPA     = 1'b1;
            12'o7600: op7_dec.CLA2    = 1'b1;
            default:  op7_dec = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        ir_d        = ir_q;
        base_d      = base_q;
        mem_d       = mem_q;
        op7_d       = op7_q;
        ifu_rd_req  = 1'b0;
        ifu_rd_addr = '0;
        ifu_wr_req  = 1'b0;
        ifu_wr_addr = '0;
        ifu_wr_data = '0;
`ifdef AUTOINDEX_EN
        auto_d      = auto_q;
`endif

        case (state_q)
            FETCH_REQ: begin
                ifu_rd_req  = 1'b1;
                ifu_rd_addr = fetch_pc_q;
                state_d     = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                ir_d    = ifu_rd_data;
                state_d = DECODE;
            end
            DECODE: begin
                if (ir_q[11:9] <= 3'd5) begin
                    if (ir_q[8]) begin
                        state_d = IND_REQ;
                    end else begin
                        mem_d               = mem_dec;
                        mem_d.mem_inst_addr = dir_addr;
                        base_d              = dir_addr;
                        state_d             = ISSUE;
                    end
                end else if (ir_q == 12'o7402) begin
                    state_d = HALT;
                end else begin
                    // IOT and unrecognised operate words go out as all-zero.
                    op7_d   = (ir_q[11:9] == 3'd7) ? op7_dec : '0;
                    base_d  = '0;
                    state_d = ISSUE;
                end
            end
            IND_REQ: begin
                ifu_rd_req  = 1'b1;
                ifu_rd_addr = dir_addr;
                state_d     = IND_WAIT;
            end
            IND_WAIT: begin
`ifdef AUTOINDEX_EN
                if (is_auto) begin
                    auto_d  = ifu_rd_data + 12'd1;
                    state_d = AUTO_WR;
                end else
`endif
                begin
                    mem_d               = mem_dec;
                    mem_d.mem_inst_addr = ifu_rd_data;
                    base_d              = ifu_rd_data;
                    state_d             = ISSUE;
                end
            end
`ifdef AUTOINDEX_EN
            AUTO_WR: begin
                // dir_addr still names the pointer: IR and fetch_pc are unchanged.
                ifu_wr_req          = 1'b1;
                ifu_wr_addr         = dir_addr;
                ifu_wr_data         = auto_q;
                mem_d               = mem_dec;
                mem_d.mem_inst_addr = auto_q;
                base_d              = auto_q;
                state_d             = ISSUE;
            end
`endif
            ISSUE: begin
                if (stall) state_d = EXEC_WAIT;
            end
            EXEC_WAIT: begin
                if (!stall) begin
                    fetch_pc_d = PC_value;
                    mem_d      = '0;
                    op7_d      = '0;
                    base_d     = '0;
                    state_d    = FETCH_REQ;
                end
            end
            HALT: state_d = HALT;
            default: state_d = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= FETCH_REQ;
            fetch_pc_q <= START_ADDRESS;
            ir_q       <= '0;
            base_q     <= '0;
            mem_q      <= '0;
            op7_q      <= '0;
`ifdef AUTOINDEX_EN
            auto_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            base_q     <= base_d;
            mem_q      <= mem_d;
            op7_q      <= op7_d;
`ifdef AUTOINDEX_EN
            auto_q     <= auto_d;
`endif
        end
    end

    assign base_addr      = base_q;
    assign pdp_mem_opcode = mem_q;
    assign pdp_op7_opcode = op7_q;
    assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed scenarios followed by
// random instruction streams, each checked against a cycle-level expectation
// derived from the instruction-set rules.
module tb_instr_fetch_decode;
    import pdp_pkg::*;

`ifdef AUTOINDEX_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            ifu_rd_req, ifu_wr_req, halted;
    logic [11:0]     ifu_rd_addr, ifu_wr_addr, ifu_wr_data, base_addr;
    logic [11:0]     ifu_rd_data = '0;
    logic            stall = 1'b0;
    logic [11:0]     PC_value = '0;
    pdp_mem_opcode_s pdp_mem_opcode;
    pdp_op7_opcode_s pdp_op7_opcode;

    logic [11:0] mem     [4096];
    logic [11:0] ref_mem [4096];
    logic [11:0] op7_words [21] = '{12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010,
        12'o7012, 12'o7020, 12'o7040, 12'o7041, 12'o7100, 12'o7200, 12'o7300,
        12'o7404, 12'o7410, 12'o7420, 12'o7430, 12'o7440, 12'o7450, 12'o7500,
        12'o7510, 12'o7600};

    int n_chk = 0;
    int n_fail = 0;

    instr_fetch_decode dut (
        .clk(clk), .reset_n(reset_n),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
        .ifu_wr_req(ifu_wr_req), .ifu_wr_addr(ifu_wr_addr), .ifu_wr_data(ifu_wr_data),
        .stall(stall), .PC_value(PC_value), .base_addr(base_addr),
        .pdp_mem_opcode(pdp_mem_opcode), .pdp_op7_opcode(pdp_op7_opcode),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory: registered read, one cycle latency; write-back from autoindex.
    always @(posedge clk) begin
        if (ifu_rd_req) ifu_rd_data <= mem[ifu_rd_addr];
        if (ifu_wr_req) mem[ifu_wr_addr] <= ifu_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    always @(negedge clk)
        if (reset_n) chk("rd_wr_exclusive", 32'(ifu_rd_req & ifu_wr_req), 32'd0);

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req(output logic [11:0] a);
        int n = 0;
        while (ifu_rd_req !== 1'b1 && n < 20) begin step(); n++; end
        chk("fetch_req_seen", 32'(ifu_rd_req), 32'd1);
        a = ifu_rd_addr;
    endtask

    // Reference: what the issued instruction must look like, from the
    // PDP-8 addressing rules.  Updates ref_mem for autoindex side effects.
    function automatic void model(input int pc, input int ir, output int lat,
                                  output logic [17:0] em, output logic [20:0] eo,
                                  output int eb, output bit halt, output int ptr,
                                  output int wa, output int wd);
        int op = ir / 512;
        int ea;
        em = '0; eo = '0; eb = 0; halt = 0; lat = 3; ptr = -1; wa = -1; wd = 0;
        if (op < 6) begin
            ea = ((ir / 128) % 2 == 1) ? (pc / 128) * 128 + ir % 128 : ir % 128;
            if ((ir / 256) % 2 == 1) begin
                lat = 5;
                ptr = ea;
                if (AUTO && ea >= 8 && ea <= 15) begin
                    ref_mem[ea] = 12'((int'(ref_mem[ea]) + 1) % 4096);
                    wa = ea; wd = int'(ref_mem[ea]); lat = 6;
                end
                ea = int'(ref_mem[ea]);
            end
            eb = ea;
            em = (18'd1 << (17 - op)) | 18'(ea);
        end else if (ir == 'o7402) begin
            halt = 1;
        end else if (op == 7) begin
            for (int i = 0; i < 21; i++)
                if (int'(op7_words[i]) == ir) eo = 21'd1 << (20 - i);
        end
    endfunction

    task automatic run_one(input logic [11:0] pc, input logic [11:0] ir, input bit early,
                           input int hold_low, input int hold_high, input logic [11:0] nxt);
        int lat, eb, ptr, wa, wd;
        bit halt;
        logic [17:0] em;
        logic [20:0] eo;
        logic [11:0] a;
        mem[pc] = ir;
        ref_mem[pc] = ir;
        model(int'(pc), int'(ir), lat, em, eo, eb, halt, ptr, wa, wd);
        wait_req(a);
        chk("fetch_addr", 32'(a), 32'(pc));
        if (early) stall = 1'b1;
        if (halt) begin
            for (int c = 1; c <= 12; c++) begin
                step();
                chk("halt_no_rd_req", 32'(ifu_rd_req), 32'd0);
                chk("halted", 32'(halted), 32'(c >= 3));
            end
        end else begin
            for (int c = 1; c < lat; c++) begin
                step();
                chk("fetch_mem_zero", 32'(pdp_mem_opcode), 32'd0);
                chk("fetch_op7_zero", 32'(pdp_op7_opcode), 32'd0);
                chk("ind_rd_req", 32'(ifu_rd_req), 32'(c == 3 && lat >= 5));
                if (c == 3 && lat >= 5) chk("ind_rd_addr", 32'(ifu_rd_addr), 32'(ptr));
                chk("auto_wr_req", 32'(ifu_wr_req), 32'(c == 5 && wa >= 0));
                if (c == 5 && wa >= 0) begin
                    chk("auto_wr_addr", 32'(ifu_wr_addr), 32'(wa));
                    chk("auto_wr_data", 32'(ifu_wr_data), 32'(wd));
                end
            end
            step();
            chk("issue_mem", 32'(pdp_mem_opcode), 32'(em));
            chk("issue_op7", 32'(pdp_op7_opcode), 32'(eo));
            chk("issue_base", 32'(base_addr), 32'(eb));
            chk("issue_not_halted", 32'(halted), 32'd0);
            if (!early) begin
                for (int i = 0; i < hold_low; i++) begin
                    step();
                    chk("hold_mem", 32'(pdp_mem_opcode), 32'(em));
                    chk("hold_base", 32'(base_addr), 32'(eb));
                    chk("hold_no_req", 32'(ifu_rd_req), 32'd0);
                end
            end
            stall = 1'b1;
            for (int i = 0; i < hold_high; i++) begin
                step();
                chk("stall_mem", 32'(pdp_mem_opcode), 32'(em));
                chk("stall_op7", 32'(pdp_op7_opcode), 32'(eo));
                chk("stall_no_req", 32'(ifu_rd_req), 32'd0);
            end
            stall = 1'b0;
            PC_value = nxt;
            step();
            chk("release_mem_zero", 32'(pdp_mem_opcode), 32'd0);
            chk("release_op7_zero", 32'(pdp_op7_opcode), 32'd0);
            chk("next_rd_req", 32'(ifu_rd_req), 32'd1);
            chk("next_rd_addr", 32'(ifu_rd_addr), 32'(nxt));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a, pc, nxt, ir;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 12'($urandom_range(0, 4095));
            ref_mem[i] = mem[i];
        end
        reset_n = 1'b0;
        step(); step();
        chk("reset_mem", 32'(pdp_mem_opcode), 32'd0);
        chk("reset_op7", 32'(pdp_op7_opcode), 32'd0);
        chk("reset_base", 32'(base_addr), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_wr_req", 32'(ifu_wr_req), 32'd0);
        reset_n = 1'b1;

        // TAD direct current page, then AND indirect through page zero with a
        // long low-stall hold and a 4-cycle stall ending at 0377.
        run_one(12'o0200, 12'o1250, 1'b0, 2, 1, 12'o0201);
        mem[12'o0020] = 12'o3456; ref_mem[12'o0020] = 12'o3456;
        run_one(12'o0201, 12'o0420, 1'b0, 10, 4, 12'o0377);
        run_one(12'o0377, 12'o7300, 1'b0, 0, 2, 12'o0400);
        run_one(12'o0400, 12'o6001, 1'b1, 0, 3, 12'o7777);
        // Current-page reference on the last page, then PC wraps to 0000.
        run_one(12'o7777, 12'o5377, 1'b1, 0, 1, 12'o0000);
        run_one(12'o0000, 12'o7001, 1'b0, 1, 1, 12'o0010);

        pc = 12'o0010;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    ir = 12'($urandom_range(0, 5) * 512 + $urandom_range(0, 511));
                2:       ir = ($urandom_range(0, 1) == 1) ? op7_words[$urandom_range(0, 20)]
                                                          : 12'('o7000 + $urandom_range(0, 511));
                default: ir = 12'('o6000 + $urandom_range(0, 511));
            endcase
            if (ir == 12'o7402) ir = 12'o7000;
            nxt = (k == 39) ? 12'o0600 : 12'($urandom_range(0, 4095));
            run_one(pc, ir, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(1, 3), nxt);
            pc = nxt;
        end

        // Reset while the indirect read is outstanding.
        mem[12'o0600] = 12'o1420; ref_mem[12'o0600] = 12'o1420;
        wait_req(a);
        chk("abort_fetch_addr", 32'(a), 32'o0600);
        for (int c = 1; c <= 4; c++) step();
        reset_n = 1'b0;
        step();
        chk("abort_mem", 32'(pdp_mem_opcode), 32'd0);
        chk("abort_op7", 32'(pdp_op7_opcode), 32'd0);
        chk("abort_base", 32'(base_addr), 32'd0);
        chk("abort_halted", 32'(halted), 32'd0);
        chk("abort_wr_req", 32'(ifu_wr_req), 32'd0);
        chk("abort_rd_addr", 32'(ifu_rd_addr), 32'o0200);
        reset_n = 1'b1;

        // Indirect through an autoindex location, then HLT.
        mem[12'o0010] = 12'o0777; ref_mem[12'o0010] = 12'o0777;
        run_one(12'o0200, 12'o1410, 1'b0, 1, 2, 12'o0300);
        run_one(12'o0300, 12'o7402, 1'b0, 0, 1, 12'o0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
